// File: rtl/tbird_light_fsm_pkg.sv
// -----------------------------------------------------------------------------
// tbird_light_fsm_pkg
// Shared constants for the Thunderbird tail-light sequencer:
//   - 4-bit state-class codes consumed by the hex text decoder
//     (IDLE/LEFT/RIGHT/HAZARD; the decoder relies on these exact values)
//   - 3-bit internal FSM state codes
//   - six-lamp light patterns, ordered {LC,LB,LA,RA,RB,RC}
//   - Moore decode helpers from state to lights and to class code
// -----------------------------------------------------------------------------
package tbird_light_fsm_pkg;

    // Class codes shown on HEX0-HEX5
    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] LEFT   = 4'd1;
    localparam logic [3:0] RIGHT  = 4'd2;
    localparam logic [3:0] HAZARD = 4'd3;

    // Sequencer states
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_L1   = 3'd1;
    localparam logic [2:0] S_L2   = 3'd2;
    localparam logic [2:0] S_L3   = 3'd3;
    localparam logic [2:0] S_R1   = 3'd4;
    localparam logic [2:0] S_R2   = 3'd5;
    localparam logic [2:0] S_R3   = 3'd6;
    localparam logic [2:0] S_LR3  = 3'd7;

    // Lamp patterns {LC,LB,LA,RA,RB,RC}
    localparam logic [5:0] LT_OFF = 6'b000000;
    localparam logic [5:0] LT_L1  = 6'b001000;
    localparam logic [5:0] LT_L2  = 6'b011000;
    localparam logic [5:0] LT_L3  = 6'b111000;
    localparam logic [5:0] LT_R1  = 6'b000100;
    localparam logic [5:0] LT_R2  = 6'b000110;
    localparam logic [5:0] LT_R3  = 6'b000111;
    localparam logic [5:0] LT_ALL = 6'b111111;

    function automatic logic [5:0] lights_of(input logic [2:0] s);
        case (s)
            S_L1:    lights_of = LT_L1;
            S_L2:    lights_of = LT_L2;
            S_L3:    lights_of = LT_L3;
            S_R1:    lights_of = LT_R1;
            S_R2:    lights_of = LT_R2;
            S_R3:    lights_of = LT_R3;
            S_LR3:   lights_of = LT_ALL;
            default: lights_of = LT_OFF;
        endcase
    endfunction

    // While hazard is held the FSM toggles S_LR3/S_IDLE; reporting HAZARD
    // in the dark half keeps the display from flickering.
    function automatic logic [3:0] csl_of(input logic [2:0] s, input logic hs);
        case (s)
            S_L1, S_L2, S_L3: csl_of = LEFT;
            S_R1, S_R2, S_R3: csl_of = RIGHT;
            S_LR3:            csl_of = HAZARD;
            default:          csl_of = hs ? HAZARD : IDLE;
        endcase
    endfunction

endpackage

// File: rtl/tbird_light_fsm_if.sv
// -----------------------------------------------------------------------------
// tbird_light_fsm_if
// Switch inputs and lamp/display outputs of the tail-light sequencer.
//   left, right, haz : raw switches (asynchronous to clk)
//   lights[5:0]      : {LC,LB,LA,RA,RB,RC}, 1 = lamp on
//   csl[3:0]         : state-class code for the hex decoder
//   tick             : one-cycle sequencer step strobe
// master drives the switches and observes the outputs; slave is the sequencer.
// -----------------------------------------------------------------------------
interface tbird_light_fsm_if;
    logic       left;
    logic       right;
    logic       haz;
    logic [5:0] lights;
    logic [3:0] csl;
    logic       tick;

    modport master (output left, right, haz, input lights, csl, tick);
    modport slave  (input left, right, haz, output lights, csl, tick);
endinterface

// File: rtl/tbird_light_fsm_tick_gen.sv
// -----------------------------------------------------------------------------
// tbird_light_fsm_tick_gen
// Divides clk into a one-cycle step strobe.
//   clk   : board clock
//   reset : synchronous, active-high; clears the count
//   tick  : high exactly while the count equals TICK_DIV-1
// The count runs 0..TICK_DIV-1, so the first tick after reset release
// appears TICK_DIV cycles later and then every TICK_DIV cycles.
// -----------------------------------------------------------------------------
module tbird_light_fsm_tick_gen #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int              CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/tbird_light_fsm.sv
// -----------------------------------------------------------------------------
// tbird_light_fsm
// Thunderbird tail-light sequencer.
//   clk   : board clock
//   reset : synchronous, active-high
//   bus   : slave side of tbird_light_fsm_if
//           (left/right/haz in; lights, csl, tick out)
// Switches are synchronised through two flops each, a divider produces the
// step tick, and the state register advances only on tick. Lights and csl
// are Moore decodes of the state (csl also looks at the synchronised hazard).
// -----------------------------------------------------------------------------
module tbird_light_fsm #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic              clk,
    input  logic              reset,
    tbird_light_fsm_if.slave  bus
);
    import tbird_light_fsm_pkg::*;

    logic       tick;
    logic [2:0] sync1_d, sync1_q;   // {haz, right, left}
    logic [2:0] sync2_d, sync2_q;
    logic       ls, rs, hs;
    logic [2:0] state_d, state_q;

    tbird_light_fsm_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        sync1_d = {bus.haz, bus.right, bus.left};
        sync2_d = sync1_q;
    end

    assign {hs, rs, ls} = sync2_q;

    // Turn sequences run to completion once started; only hazard cuts in.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (hs || (ls && rs)) state_d = S_LR3;
                    else if (ls)          state_d = S_L1;
                    else if (rs)          state_d = S_R1;
                    else                  state_d = S_IDLE;
                end
                S_L1:    state_d = hs ? S_LR3 : S_L2;
                S_L2:    state_d = hs ? S_LR3 : S_L3;
                S_R1:    state_d = hs ? S_LR3 : S_R2;
                S_R2:    state_d = hs ? S_LR3 : S_R3;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= S_IDLE;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
        end
    end

    assign bus.lights = lights_of(state_q);
    assign bus.csl    = csl_of(state_q, hs);
    assign bus.tick   = tick;

endmodule

// File: tb/tb_tbird_light_fsm.sv
// -----------------------------------------------------------------------------
// tb_tbird_light_fsm
// Scoreboard bench for the tail-light sequencer with TICK_DIV = 4.
// Each stimulus step sets the switches right after a tick edge and queues the
// lights/csl expected after the following tick edge; a monitor pops and
// compares one entry half a cycle after every tick edge.
// -----------------------------------------------------------------------------
module tb_tbird_light_fsm;
    import tbird_light_fsm_pkg::*;

    localparam int TICK_DIV = 4;

    typedef struct packed {
        logic [5:0] lights;
        logic [3:0] csl;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    tbird_light_fsm_if bus();

    tbird_light_fsm #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic armed    = 1'b0;
    logic pend     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pend marks that the coming posedge is a tick edge.
    always @(negedge clk) begin
        if (pend) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: tick with no expected entry at %0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("lights", {26'd0, bus.lights}, {26'd0, mon_e.lights});
                check("csl",    {28'd0, bus.csl},    {28'd0, mon_e.csl});
            end
        end
        pend = armed && bus.tick;
    end

    // Returns 1 time unit after the next tick edge.
    task automatic wait_tick();
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.tick) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_tick: no tick within 20 cycles at %0t", $time);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    // Set switches, queue the result of the next tick, and move to that tick.
    // pulse: hold right for only 3 cycles, then drop it.
    task automatic apply(input logic l, input logic r, input logic h, input logic pulse,
                         input logic [5:0] el, input logic [3:0] ec);
        exp_t e;
        bus.left  = l;
        bus.right = r;
        bus.haz   = h;
        e.lights  = el;
        e.csl     = ec;
        sb_q.push_back(e);
        armed = 1'b1;
        if (pulse) begin
            repeat (3) @(posedge clk);
            #1;
            bus.right = 1'b0;
        end
        wait_tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.left  = 1'b0;
        bus.right = 1'b0;
        bus.haz   = 1'b0;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_lights", {26'd0, bus.lights}, 32'd0);
        check("reset_csl",    {28'd0, bus.csl},    32'd0);
        check("reset_tick",   {31'd0, bus.tick},   32'd0);
        reset = 1'b0;

        // First tick on the 4th cycle after release, then every 4.
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            #1;
            check("tick_after_reset", {31'd0, bus.tick}, (n % 4 == 3) ? 32'd1 : 32'd0);
        end

        wait_tick();

        // left held, then dropped mid-sequence
        apply(1, 0, 0, 0, 6'b001000, 4'd1);
        apply(1, 0, 0, 0, 6'b011000, 4'd1);
        apply(1, 0, 0, 0, 6'b111000, 4'd1);
        apply(1, 0, 0, 0, 6'b000000, 4'd0);
        apply(1, 0, 0, 0, 6'b001000, 4'd1);
        apply(0, 0, 0, 0, 6'b011000, 4'd1);
        apply(0, 0, 0, 0, 6'b111000, 4'd1);
        apply(0, 0, 0, 0, 6'b000000, 4'd0);
        // 3-cycle right pulse runs the full right sequence
        apply(0, 1, 0, 1, 6'b000100, 4'd2);
        apply(0, 0, 0, 0, 6'b000110, 4'd2);
        apply(0, 0, 0, 0, 6'b000111, 4'd2);
        apply(0, 0, 0, 0, 6'b000000, 4'd0);
        // hazard while in S_L2, then hazard flashing
        apply(1, 0, 0, 0, 6'b001000, 4'd1);
        apply(1, 0, 0, 0, 6'b011000, 4'd1);
        apply(1, 0, 1, 0, 6'b111111, 4'd3);
        apply(0, 0, 1, 0, 6'b000000, 4'd3);
        apply(0, 0, 1, 0, 6'b111111, 4'd3);
        apply(0, 0, 1, 0, 6'b000000, 4'd3);
        apply(0, 0, 0, 0, 6'b000000, 4'd0);
        // left and right together behave as hazard
        apply(1, 1, 0, 0, 6'b111111, 4'd3);
        apply(1, 1, 0, 0, 6'b000000, 4'd0);
        apply(0, 0, 0, 0, 6'b000000, 4'd0);
        // reach S_R2 for the mid-sequence reset
        apply(0, 1, 0, 0, 6'b000100, 4'd2);
        apply(0, 0, 0, 0, 6'b000110, 4'd2);

        @(negedge clk);
        #1;
        armed = 1'b0;

        // Reset between ticks with hazard up: synchronisers must stay clear.
        bus.haz = 1'b1;
        reset   = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            check("midreset_lights", {26'd0, bus.lights}, 32'd0);
            check("midreset_csl",    {28'd0, bus.csl},    32'd0);
            check("midreset_tick",   {31'd0, bus.tick},   32'd0);
        end
        reset   = 1'b0;
        bus.haz = 1'b0;

        for (int n = 1; n <= 4; n++) begin
            @(posedge clk);
            #1;
            check("tick_restart", {31'd0, bus.tick}, (n == 3) ? 32'd1 : 32'd0);
        end

        check("sb_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
